// File: rtl/spill_stack_pkg.sv
// Shared types and helpers for the spilling hardware stack.
package spill_stack_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSpill,
    StFill
  } state_e;

  // Byte address of spilled cell idx; cells are two bytes apart.
  function automatic logic [31:0] cell_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 1);
  endfunction

  function automatic bit params_ok(input int unsigned hi, input int unsigned lo,
                                   input int unsigned dep);
    return (hi > lo) && (hi <= (2 ** dep)) && ((2 ** dep) >= 4);
  endfunction

endpackage

// File: rtl/spill_stack_ring.sv
// On-chip ring of 2^DEP cells: push/replace port at top, fill port at bottom.
module spill_ring #(
  parameter int unsigned L   = 16,
  parameter int unsigned DEP = 2
) (
  input  logic           clk,
  input  logic           top_we,
  input  logic [DEP-1:0] top_waddr,
  input  logic [L-1:0]   top_wdata,
  input  logic           bot_we,
  input  logic [DEP-1:0] bot_waddr,
  input  logic [L-1:0]   bot_wdata,
  input  logic [DEP-1:0] top_raddr,
  output logic [L-1:0]   top_rdata,
  input  logic [DEP-1:0] bot_raddr,
  output logic [L-1:0]   bot_rdata
);

  logic [L-1:0] cells [2 ** DEP];

  // The controller never aims both ports at the same cell in one cycle.
  always_ff @(posedge clk) begin
    if (top_we) cells[top_waddr] <= top_wdata;
    if (bot_we) cells[bot_waddr] <= bot_wdata;
  end

  assign top_rdata = cells[top_raddr];
  assign bot_rdata = cells[bot_raddr];

endmodule

// File: rtl/spill_stack.sv
// Deep CPU stack: on-chip ring that spills/fills its oldest cells over a req/ack bus.
// Optional high-water-mark output enabled by defining SPILL_STACK_HWM_EN.
module spill_stack
  import spill_stack_pkg::*;
#(
  parameter int unsigned  L    = 16,
  parameter int unsigned  DEP  = 2,
  parameter int unsigned  MDEP = 8,
  parameter logic [L-1:0] BASE = 16'hE000,
  parameter int unsigned  HI   = (2 ** DEP) - 1,
  parameter int unsigned  LO   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [L-1:0]    in,
  output logic [L-1:0]    out,
  output logic            push_ok,
  output logic            pop_ok,
  output logic [DEP:0]    cnt,
  output logic [MDEP:0]   mcnt,
  output logic [L-1:0]    mem_addr,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [L-1:0]    mem_wdata,
  input  logic [L-1:0]    mem_rdata,
  input  logic            mem_ack,
  output logic            ovf,
  output logic            unf,
  input  logic            clr_err
`ifdef SPILL_STACK_HWM_EN
  ,
  output logic [MDEP+1:0] hwm
`endif
);

  localparam int unsigned   CAP    = 2 ** DEP;
  localparam logic [DEP:0]  CapC   = (DEP + 1)'(CAP);
  localparam logic [DEP:0]  HiC    = (DEP + 1)'(HI);
  localparam logic [DEP:0]  LoC    = (DEP + 1)'(LO);
  localparam logic [DEP:0]  CntOne = (DEP + 1)'(1);
  localparam logic [DEP-1:0] PtrOne = DEP'(1);
  localparam logic [MDEP:0] MOne   = (MDEP + 1)'(1);

  if (!params_ok(HI, LO, DEP)) begin : g_param_check
    $error("spill_stack: requires HI > LO, HI <= 2**DEP and 2**DEP >= 4");
  end

  // bot_q points one cell below the oldest on-chip cell, so top_q - bot_q == cnt.
  logic [DEP-1:0] top_q, top_d, bot_q, bot_d;
  logic [DEP:0]   cnt_q, cnt_d;
  logic [MDEP:0]  mcnt_q, mcnt_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  state_e         state_q;
  logic           mem_rd_q, mem_wr_q;
  logic [L-1:0]   mem_addr_q;

  logic           do_push, do_pop, push_only, pop_only;
  logic           ovf_set, unf_set, spill_ack, fill_ack, mfull;
  logic [DEP-1:0] top_waddr, bot_raddr;
  logic [L-1:0]   top_rdata, bot_rdata;

  always_comb begin
    do_pop    = pop && (cnt_q != '0);
    do_push   = push && ((cnt_q != CapC) || do_pop);
    push_only = do_push && !do_pop;
    pop_only  = do_pop && !do_push;
    ovf_set   = push && !do_push;
    unf_set   = pop && (cnt_q == '0) && (mcnt_q == '0);
    spill_ack = (state_q == StSpill) && mem_ack;
    fill_ack  = (state_q == StFill) && mem_ack;
    mfull     = mcnt_q[MDEP];
    top_waddr = do_pop ? top_q : top_q + PtrOne;
    bot_raddr = bot_q + PtrOne;
  end

  always_comb begin
    top_d = top_q;
    if (push_only) top_d = top_q + PtrOne;
    else if (pop_only) top_d = top_q - PtrOne;

    bot_d = bot_q;
    if (spill_ack) bot_d = bot_q + PtrOne;
    else if (fill_ack) bot_d = bot_q - PtrOne;

    // CPU and memory side contributions simply add up.
    cnt_d = cnt_q;
    if (push_only) cnt_d = cnt_d + CntOne;
    if (pop_only)  cnt_d = cnt_d - CntOne;
    if (spill_ack) cnt_d = cnt_d - CntOne;
    if (fill_ack)  cnt_d = cnt_d + CntOne;

    mcnt_d = mcnt_q;
    if (spill_ack) mcnt_d = mcnt_q + MOne;
    else if (fill_ack) mcnt_d = mcnt_q - MOne;

    ovf_d = (ovf_q && !clr_err) || ovf_set;
    unf_d = (unf_q && !clr_err) || unf_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q  <= '0;
      bot_q  <= '0;
      cnt_q  <= '0;
      mcnt_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      top_q  <= top_d;
      bot_q  <= bot_d;
      cnt_q  <= cnt_d;
      mcnt_q <= mcnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Transfer FSM; requests are registered and drop the cycle after ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= BASE;
    end else begin
      unique case (state_q)
        StIdle: begin
          if ((cnt_q >= HiC) && !mfull) begin
            state_q    <= StSpill;
            mem_wr_q   <= 1'b1;
            mem_addr_q <= L'(cell_addr(32'(BASE), 32'(mcnt_q)));
          end else if ((cnt_q <= LoC) && (mcnt_q != '0)) begin
            state_q    <= StFill;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= L'(cell_addr(32'(BASE), 32'(mcnt_q - MOne)));
          end
        end
        StSpill: begin
          if (mem_ack) begin
            state_q  <= StIdle;
            mem_wr_q <= 1'b0;
          end
        end
        StFill: begin
          if (mem_ack) begin
            state_q  <= StIdle;
            mem_rd_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          mem_wr_q <= 1'b0;
          mem_rd_q <= 1'b0;
        end
      endcase
    end
  end

  spill_ring #(
    .L   (L),
    .DEP (DEP)
  ) u_ring (
    .clk       (clk),
    .top_we    (do_push),
    .top_waddr (top_waddr),
    .top_wdata (in),
    .bot_we    (fill_ack),
    .bot_waddr (bot_q),
    .bot_wdata (mem_rdata),
    .top_raddr (top_q),
    .top_rdata (top_rdata),
    .bot_raddr (bot_raddr),
    .bot_rdata (bot_rdata)
  );

`ifdef SPILL_STACK_HWM_EN
  logic [MDEP+1:0] hwm_q, total;

  assign total = (MDEP + 2)'(cnt_q) + (MDEP + 2)'(mcnt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hwm_q <= '0;
    end else if (clr_err) begin
      hwm_q <= '0;
    end else if (total > hwm_q) begin
      hwm_q <= total;
    end
  end

  assign hwm = hwm_q;
`endif

  assign out       = top_rdata;
  assign push_ok   = (cnt_q != CapC);
  assign pop_ok    = (cnt_q != '0);
  assign cnt       = cnt_q;
  assign mcnt      = mcnt_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = bot_rdata;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_spill_stack.sv
// Directed bench for spill_stack: spill/fill ordering, errors, full spill area, reset abort.
module tb_spill_stack;

  localparam logic [15:0] BASE = 16'hE000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // Main instance (MDEP=8)
  logic        push = 1'b0, pop = 1'b0, clr_err = 1'b0, mem_ack = 1'b0;
  logic [15:0] in_data = '0, mem_rdata = '0;
  logic [15:0] out, mem_addr, mem_wdata;
  logic        push_ok, pop_ok, mem_rd, mem_wr, ovf, unf;
  logic [2:0]  cnt;
  logic [8:0]  mcnt;

  // Small spill area instance (MDEP=1)
  logic        push2 = 1'b0, mem_ack2 = 1'b0;
  logic [15:0] in2 = '0;
  logic [15:0] out2, mem_addr2, mem_wdata2;
  logic        push_ok2, pop_ok2, mem_rd2, mem_wr2, ovf2, unf2;
  logic [2:0]  cnt2;
  logic [1:0]  mcnt2;

`ifdef SPILL_STACK_HWM_EN
  logic [9:0] hwm;
  logic [2:0] hwm2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [256];
  logic [15:0] spill_log [$];
  logic [15:0] fill_log [$];
  int unsigned ack_delay = 0;
  int unsigned waited = 0;
  bit          ack_block = 1'b0;

  always #5 clk = ~clk;

  spill_stack dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .in        (in_data),
    .out       (out),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .cnt       (cnt),
    .mcnt      (mcnt),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .ovf       (ovf),
    .unf       (unf),
    .clr_err   (clr_err)
`ifdef SPILL_STACK_HWM_EN
    ,
    .hwm       (hwm)
`endif
  );

  spill_stack #(
    .MDEP (1)
  ) dut2 (
    .clk       (clk),
    .reset     (reset),
    .push      (push2),
    .pop       (1'b0),
    .in        (in2),
    .out       (out2),
    .push_ok   (push_ok2),
    .pop_ok    (pop_ok2),
    .cnt       (cnt2),
    .mcnt      (mcnt2),
    .mem_addr  (mem_addr2),
    .mem_rd    (mem_rd2),
    .mem_wr    (mem_wr2),
    .mem_wdata (mem_wdata2),
    .mem_rdata (16'h0000),
    .mem_ack   (mem_ack2),
    .ovf       (ovf2),
    .unf       (unf2),
    .clr_err   (1'b0)
`ifdef SPILL_STACK_HWM_EN
    ,
    .hwm       (hwm2)
`endif
  );

  // Memory model: ack arrives ack_delay+1 cycles after the request appears.
  initial begin : mem_model
    logic [7:0] idx;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if ((mem_wr || mem_rd) && !ack_block) begin
        if (waited >= ack_delay) begin
          waited  = 0;
          mem_ack = 1'b1;
          idx     = 8'((mem_addr - BASE) >> 1);
          if (mem_wr) begin
            mem[idx] = mem_wdata;
            spill_log.push_back(mem_addr);
          end else begin
            mem_rdata = mem[idx];
            fill_log.push_back(mem_addr);
          end
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  initial begin : mem_model2
    forever begin
      @(negedge clk);
      mem_ack2 = (mem_wr2 || mem_rd2) && !mem_ack2;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input logic [15:0] exp);
    int n;
    n = 0;
    while (!pop_ok && n < 50) begin
      step();
      n++;
    end
    check("pop_ok_wait", 32'(pop_ok), 32'd1);
    check("pop_value", 32'(out), 32'(exp));
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  initial begin : stim
    int n;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_mcnt", 32'(mcnt), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'hE000);
    check("rst_ovf_unf", 32'({ovf, unf}), 32'd0);
    check("rst_ok", 32'({push_ok, pop_ok}), 32'b10);

    // First spill, ack one cycle after request
    ack_delay = 0;
    push = 1'b1; in_data = 16'h1111; step();
    in_data = 16'h2222; step();
    in_data = 16'h3333; step();
    push = 1'b0;
    check("p1_cnt3", 32'(cnt), 32'd3);
    check("p1_top", 32'(out), 32'h3333);
    check("p1_no_wr_yet", 32'(mem_wr), 32'd0);
    step();
    check("p1_mem_wr", 32'(mem_wr), 32'd1);
    check("p1_addr", 32'(mem_addr), 32'hE000);
    check("p1_wdata", 32'(mem_wdata), 32'h1111);
    step();
    check("p1_cnt_after", 32'(cnt), 32'd2);
    check("p1_mcnt_after", 32'(mcnt), 32'd1);
    check("p1_wr_drop", 32'(mem_wr), 32'd0);

    // Push up to 8 total with slower memory
    ack_delay = 2;
    for (int i = 4; i <= 8; i++) begin
      n = 0;
      while (!push_ok && n < 50) begin
        step();
        n++;
      end
      check("p2_push_ok_wait", 32'(push_ok), 32'd1);
      push = 1'b1;
      in_data = 16'(i * 16'h1111);
      step();
      push = 1'b0;
    end
    n = 0;
    while (!(cnt == 3'd2 && mcnt == 9'd6 && !mem_wr) && n < 100) begin
      step();
      n++;
    end
    check("p2_cnt", 32'(cnt), 32'd2);
    check("p2_mcnt", 32'(mcnt), 32'd6);
    check("p2_ovf", 32'(ovf), 32'd0);
    check("p2_top", 32'(out), 32'h8888);
    check("p2_spill_count", 32'(spill_log.size()), 32'd6);
    for (int k = 0; k < spill_log.size(); k++)
      check("p2_spill_addr", 32'(spill_log[k]), 32'(BASE + 16'(2 * k)));
`ifdef SPILL_STACK_HWM_EN
    check("p2_hwm", 32'(hwm), 32'd8);
`endif

    // Pop all eight: LIFO order, fills walk downward
    ack_delay = 0;
    for (int i = 8; i >= 1; i--) pop_expect(16'(i * 16'h1111));
    check("p3_cnt", 32'(cnt), 32'd0);
    check("p3_mcnt", 32'(mcnt), 32'd0);
    check("p3_unf", 32'(unf), 32'd0);
    check("p3_fill_count", 32'(fill_log.size()), 32'd6);
    for (int k = 0; k < fill_log.size(); k++)
      check("p3_fill_addr", 32'(fill_log[k]), 32'(BASE + 16'(2 * (5 - k))));

    // Underflow, error-wins-over-clear, then clear
    pop = 1'b1; step(); pop = 1'b0;
    check("p4_unf_set", 32'(unf), 32'd1);
    check("p4_cnt", 32'(cnt), 32'd0);
    check("p4_mcnt", 32'(mcnt), 32'd0);
    pop = 1'b1; clr_err = 1'b1; step(); pop = 1'b0;
    check("p4_err_wins", 32'(unf), 32'd1);
    step(); clr_err = 1'b0;
    check("p4_unf_clr", 32'(unf), 32'd0);

    // Push+pop replaces top
    push = 1'b1; in_data = 16'hAAAA; step();
    pop = 1'b1; in_data = 16'hBBBB; step();
    push = 1'b0;
    check("p4_repl_cnt", 32'(cnt), 32'd1);
    check("p4_repl_top", 32'(out), 32'hBBBB);
    step(); pop = 1'b0;
    check("p4_pop_cnt", 32'(cnt), 32'd0);

    // MDEP=1: spill area fills, 7th push overflows
    for (int i = 1; i <= 6; i++) begin
      n = 0;
      while (!push_ok2 && n < 50) begin
        step();
        n++;
      end
      check("p5_push_ok_wait", 32'(push_ok2), 32'd1);
      push2 = 1'b1;
      in2 = 16'(i * 16'h0101);
      step();
      push2 = 1'b0;
    end
    n = 0;
    while (!(cnt2 == 3'd4 && mcnt2 == 2'd2) && n < 50) begin
      step();
      n++;
    end
    check("p5_cnt_full", 32'(cnt2), 32'd4);
    check("p5_mcnt_full", 32'(mcnt2), 32'd2);
    check("p5_no_ovf_yet", 32'(ovf2), 32'd0);
    push2 = 1'b1; in2 = 16'h0707; step(); push2 = 1'b0;
    check("p5_ovf", 32'(ovf2), 32'd1);
    check("p5_cnt", 32'(cnt2), 32'd4);
    check("p5_top", 32'(out2), 32'h0606);
    check("p5_no_spill", 32'(mem_wr2), 32'd0);

    // Reset while a spill is pending
    ack_block = 1'b1;
    push = 1'b1; in_data = 16'h1234; step();
    in_data = 16'h2345; step();
    in_data = 16'h3456; step();
    push = 1'b0;
    step();
    step();
    step();
    check("p6_pending", 32'(mem_wr), 32'd1);
    reset = 1'b1;
    #1;
    check("p6_wr_drop", 32'(mem_wr), 32'd0);
    check("p6_cnt", 32'(cnt), 32'd0);
    check("p6_mcnt", 32'(mcnt), 32'd0);
`ifdef SPILL_STACK_HWM_EN
    check("p6_hwm", 32'(hwm), 32'd0);
`endif
    step();
    reset = 1'b0;
    ack_block = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
